// File: rtl/vscale_md_requester_if.sv
// Handshake bundle between the issue stage, the md requester and the
// iterative multiply/divide unit. "master" is the requester's view;
// "slave" is the view of everything around it (issue stage, md unit, writeback).
interface vscale_md_requester_if #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // issue-stage command
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [2:0]                cmd_funct3;
    logic [XPR_LEN-1:0]        cmd_rs1;
    logic [XPR_LEN-1:0]        cmd_rs2;
    logic [REG_ADDR_WIDTH-1:0] cmd_rd;
    logic                      kill;

    // md unit request / response
    logic                      md_req_valid;
    logic                      md_req_ready;
    logic [1:0]                md_req_op;
    logic [1:0]                md_req_out_sel;
    logic                      md_req_in_1_signed;
    logic                      md_req_in_2_signed;
    logic [XPR_LEN-1:0]        md_req_in_1;
    logic [XPR_LEN-1:0]        md_req_in_2;
    logic                      md_resp_valid;
    logic [XPR_LEN-1:0]        md_resp_result;

    // writeback and status
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [XPR_LEN-1:0]        wb_data;
    logic                      busy;

    modport master (
        input  cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, cmd_rd, kill,
        output cmd_ready,
        output md_req_valid, md_req_op, md_req_out_sel,
        output md_req_in_1_signed, md_req_in_2_signed, md_req_in_1, md_req_in_2,
        input  md_req_ready, md_resp_valid, md_resp_result,
        output wb_valid, wb_rd, wb_data, busy
    );

    modport slave (
        output cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, cmd_rd, kill,
        input  cmd_ready,
        input  md_req_valid, md_req_op, md_req_out_sel,
        input  md_req_in_1_signed, md_req_in_2_signed, md_req_in_1, md_req_in_2,
        output md_req_ready, md_resp_valid, md_resp_result,
        input  wb_valid, wb_rd, wb_data, busy
    );
endinterface

// File: rtl/vscale_md_requester.sv
// Pipeline-side initiator for the iterative multiply/divide unit.
// Accepts one RV32M command at a time, translates funct3 into an md request,
// runs the req/resp handshake and presents a one-cycle writeback. Divide and
// remainder by zero are answered locally without touching the md unit.
module vscale_md_requester #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vscale_md_requester_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // funct3 -> {op[1:0], out_sel[1:0], in_1_signed, in_2_signed}
    function automatic logic [5:0] f_decode(input logic [2:0] funct3);
        logic [5:0] d;
        d = 6'b00_00_00;
        case (funct3)
            3'd0: d = {2'd0, 2'd0, 1'b1, 1'b1}; // MUL
            3'd1: d = {2'd0, 2'd1, 1'b1, 1'b1}; // MULH
            3'd2: d = {2'd0, 2'd1, 1'b1, 1'b0}; // MULHSU
            3'd3: d = {2'd0, 2'd1, 1'b0, 1'b0}; // MULHU
            3'd4: d = {2'd1, 2'd0, 1'b1, 1'b1}; // DIV
            3'd5: d = {2'd2, 2'd0, 1'b0, 1'b0}; // DIVU
            3'd6: d = {2'd3, 2'd2, 1'b1, 1'b1}; // REM
            3'd7: d = {2'd3, 2'd2, 1'b0, 1'b0}; // REMU
            default: d = 6'b00_00_00;
        endcase
        return d;
    endfunction

    // ISA result of a divide by zero: quotient is all ones, remainder is the dividend
    function automatic logic [XPR_LEN-1:0] f_div_zero_result(
        input logic [2:0]         funct3,
        input logic [XPR_LEN-1:0] rs1
    );
        return funct3[1] ? rs1 : {XPR_LEN{1'b1}};
    endfunction

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [1:0]                r_req_op;
    logic [1:0]                r_req_out_sel;
    logic                      r_req_in_1_signed;
    logic                      r_req_in_2_signed;
    logic [XPR_LEN-1:0]        r_req_in_1;
    logic [XPR_LEN-1:0]        r_req_in_2;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic [XPR_LEN-1:0]        r_wb_data;

    logic                      w_accept;
    logic                      w_div_zero;
    logic                      w_resp_commit;
    logic [5:0]                w_dec;

    assign w_accept      = (r_state == S_IDLE) && bus.cmd_valid && !bus.kill;
    assign w_div_zero    = bus.cmd_funct3[2] && (bus.cmd_rs2 == '0);
    assign w_resp_commit = (r_state == S_WAIT) && bus.md_resp_valid && !bus.kill;
    assign w_dec         = f_decode(bus.cmd_funct3);

    // Next-state logic for the single-outstanding-command handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.kill) begin
                    // a request that was accepted in the kill cycle still owes a response
                    w_state_nxt = bus.md_req_ready ? S_DRAIN : S_IDLE;
                end else if (bus.md_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.kill) begin
                    w_state_nxt = bus.md_resp_valid ? S_IDLE : S_DRAIN;
                end else if (bus.md_resp_valid) begin
                    w_state_nxt = S_WB;
                end
            end
            S_DRAIN: begin
                if (bus.md_resp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request fields: captured at acceptance and held until the next accepted command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_op          <= 2'd0;
            r_req_out_sel     <= 2'd0;
            r_req_in_1_signed <= 1'b0;
            r_req_in_2_signed <= 1'b0;
            r_req_in_1        <= '0;
            r_req_in_2        <= '0;
        end else if (w_accept && !w_div_zero) begin
            r_req_op          <= w_dec[5:4];
            r_req_out_sel     <= w_dec[3:2];
            r_req_in_1_signed <= w_dec[1];
            r_req_in_2_signed <= w_dec[0];
            r_req_in_1        <= bus.cmd_rs1;
            r_req_in_2        <= bus.cmd_rs2;
        end
    end

    // Writeback register and data: loaded by the bypass or by a committed response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_accept) begin
                r_wb_rd <= bus.cmd_rd;
            end
            if (w_accept && w_div_zero) begin
                r_wb_data <= f_div_zero_result(bus.cmd_funct3, bus.cmd_rs1);
            end else if (w_resp_commit) begin
                r_wb_data <= bus.md_resp_result;
            end
        end
    end

    assign bus.cmd_ready          = (r_state == S_IDLE);
    assign bus.busy               = (r_state != S_IDLE);
    assign bus.md_req_valid       = (r_state == S_REQ);
    assign bus.md_req_op          = r_req_op;
    assign bus.md_req_out_sel     = r_req_out_sel;
    assign bus.md_req_in_1_signed = r_req_in_1_signed;
    assign bus.md_req_in_2_signed = r_req_in_2_signed;
    assign bus.md_req_in_1        = r_req_in_1;
    assign bus.md_req_in_2        = r_req_in_2;
    assign bus.wb_valid           = (r_state == S_WB);
    assign bus.wb_rd              = r_wb_rd;
    assign bus.wb_data            = r_wb_data;

endmodule

// File: tb/tb_vscale_md_requester.sv
// Directed testbench for vscale_md_requester: a decode table swept in a loop
// plus hand-written sequences for bypass, kill, drain and async reset.
module tb_vscale_md_requester;

    localparam int XPR_LEN = 32;
    localparam int RW      = 5;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    vscale_md_requester_if #(.XPR_LEN(XPR_LEN), .REG_ADDR_WIDTH(RW)) bus ();

    vscale_md_requester #(.XPR_LEN(XPR_LEN), .REG_ADDR_WIDTH(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [1:0]  op;
        logic [1:0]  sel;
        logic        s1;
        logic        s2;
        logic [31:0] resp;
    } vec_t;

    vec_t vt [8];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.cmd_valid  = 1'b1;
        bus.cmd_funct3 = f3;
        bus.cmd_rs1    = a;
        bus.cmd_rs2    = b;
        bus.cmd_rd     = rd;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] r);
        bus.md_resp_valid  = 1'b1;
        bus.md_resp_result = r;
        tick();
        bus.md_resp_valid  = 1'b0;
        bus.md_resp_result = '0;
    endtask

    task automatic handshake();
        bus.md_req_ready = 1'b1;
        tick();
        bus.md_req_ready = 1'b0;
    endtask

    function automatic logic [31:0] dec_now();
        return {26'd0, bus.md_req_op, bus.md_req_out_sel,
                bus.md_req_in_1_signed, bus.md_req_in_2_signed};
    endfunction

    initial begin
        logic saw_wb;
        logic stable;

        vt[0] = '{3'd0, 32'h0000_0011, 32'h0000_0003, 5'd1,  2'd0, 2'd0, 1'b1, 1'b1, 32'h1000_0000};
        vt[1] = '{3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd2,  2'd0, 2'd1, 1'b1, 1'b1, 32'h1000_0001};
        vt[2] = '{3'd2, 32'hFFFF_FFFE, 32'h0000_0002, 5'd3,  2'd0, 2'd1, 1'b1, 1'b0, 32'h1000_0002};
        vt[3] = '{3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4,  2'd0, 2'd1, 1'b0, 1'b0, 32'h1000_0003};
        vt[4] = '{3'd4, 32'h0000_0064, 32'h0000_0007, 5'd5,  2'd1, 2'd0, 1'b1, 1'b1, 32'h1000_0004};
        vt[5] = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0010, 5'd30, 2'd2, 2'd0, 1'b0, 1'b0, 32'h1000_0005};
        vt[6] = '{3'd6, 32'hFFFF_FF9C, 32'h0000_0007, 5'd17, 2'd3, 2'd2, 1'b1, 1'b1, 32'h1000_0006};
        vt[7] = '{3'd7, 32'h0000_0064, 32'h0000_0009, 5'd31, 2'd3, 2'd2, 1'b0, 1'b0, 32'h1000_0007};

        reset_n            = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_funct3     = 3'd0;
        bus.cmd_rs1        = '0;
        bus.cmd_rs2        = '0;
        bus.cmd_rd         = '0;
        bus.kill           = 1'b0;
        bus.md_req_ready   = 1'b0;
        bus.md_resp_valid  = 1'b0;
        bus.md_resp_result = '0;

        // reset state, checked while reset is still asserted
        tick();
        tick();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.md_req_valid}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("rst_req_fields", dec_now(), 32'd0);
        chk("rst_req_in_1", bus.md_req_in_1, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // MUL 7*6 with a 34-cycle responder
        issue(3'd0, 32'd7, 32'd6, 5'd3);
        chk("mul_busy", {31'd0, bus.busy}, 32'd1);
        chk("mul_req_valid", {31'd0, bus.md_req_valid}, 32'd1);
        chk("mul_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("mul_decode", dec_now(), {26'd0, 2'd0, 2'd0, 1'b1, 1'b1});
        handshake();
        chk("mul_wait_req_valid", {31'd0, bus.md_req_valid}, 32'd0);
        saw_wb = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 33; c++) begin
            saw_wb = saw_wb | bus.wb_valid;
            stable = stable & bus.busy;
            tick();
        end
        chk("mul_busy_in_wait", {31'd0, stable}, 32'd1);
        respond(32'd42);
        chk("mul_no_early_wb", {31'd0, saw_wb}, 32'd0);
        chk("mul_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("mul_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("mul_wb_data", bus.wb_data, 32'd42);
        chk("mul_wb_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("mul_wb_one_cycle", {31'd0, bus.wb_valid}, 32'd0);
        chk("mul_ready_again", {31'd0, bus.cmd_ready}, 32'd1);
        chk("mul_wb_data_hold", bus.wb_data, 32'd42);

        // decode sweep with req_ready withheld for 5 cycles
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].rd);
            bus.cmd_funct3 = ~vt[i].f3;
            bus.cmd_rs1    = ~vt[i].rs1;
            bus.cmd_rs2    = 32'h5555_5555;
            bus.cmd_rd     = ~vt[i].rd;
            chk($sformatf("dec%0d_fields", i), dec_now(),
                {26'd0, vt[i].op, vt[i].sel, vt[i].s1, vt[i].s2});
            chk($sformatf("dec%0d_in_1", i), bus.md_req_in_1, vt[i].rs1);
            chk($sformatf("dec%0d_in_2", i), bus.md_req_in_2, vt[i].rs2);
            stable = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (bus.md_req_in_1 !== vt[i].rs1 || bus.md_req_in_2 !== vt[i].rs2 ||
                    bus.md_req_valid !== 1'b1 ||
                    dec_now() !== {26'd0, vt[i].op, vt[i].sel, vt[i].s1, vt[i].s2})
                    stable = 1'b0;
                tick();
            end
            chk($sformatf("dec%0d_hold", i), {31'd0, stable}, 32'd1);
            chk($sformatf("dec%0d_still_valid", i), {31'd0, bus.md_req_valid}, 32'd1);
            handshake();
            chk($sformatf("dec%0d_wait", i), {31'd0, bus.md_req_valid}, 32'd0);
            tick();
            tick();
            respond(vt[i].resp);
            chk($sformatf("dec%0d_wb_valid", i), {31'd0, bus.wb_valid}, 32'd1);
            chk($sformatf("dec%0d_wb_data", i), bus.wb_data, vt[i].resp);
            chk($sformatf("dec%0d_wb_rd", i), {27'd0, bus.wb_rd}, {27'd0, vt[i].rd});
            tick();
            chk($sformatf("dec%0d_ready", i), {31'd0, bus.cmd_ready}, 32'd1);
        end

        // divide by zero bypass
        issue(3'd4, 32'h8000_0000, 32'd0, 5'd7);
        chk("dz_div_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("dz_div_no_req", {31'd0, bus.md_req_valid}, 32'd0);
        chk("dz_div_data", bus.wb_data, 32'hFFFF_FFFF);
        chk("dz_div_rd", {27'd0, bus.wb_rd}, 32'd7);
        tick();
        chk("dz_div_ready", {31'd0, bus.cmd_ready}, 32'd1);
        issue(3'd7, 32'h0000_1234, 32'd0, 5'd9);
        chk("dz_remu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("dz_remu_no_req", {31'd0, bus.md_req_valid}, 32'd0);
        chk("dz_remu_data", bus.wb_data, 32'h0000_1234);
        tick();

        // command offered together with kill is ignored
        bus.kill = 1'b1;
        issue(3'd0, 32'd1, 32'd1, 5'd2);
        bus.kill = 1'b0;
        chk("kill_idle_busy", {31'd0, bus.busy}, 32'd0);

        // kill in REQ without handshake
        issue(3'd1, 32'd5, 32'd5, 5'd4);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("kill_req_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("kill_req_no_valid", {31'd0, bus.md_req_valid}, 32'd0);
        saw_wb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            saw_wb = saw_wb | bus.wb_valid;
            tick();
        end
        chk("kill_req_no_wb", {31'd0, saw_wb}, 32'd0);

        // kill coincident with handshake: drain the response
        issue(3'd0, 32'd3, 32'd3, 5'd8);
        bus.kill         = 1'b1;
        bus.md_req_ready = 1'b1;
        tick();
        bus.kill         = 1'b0;
        bus.md_req_ready = 1'b0;
        chk("drain_busy", {31'd0, bus.busy}, 32'd1);
        chk("drain_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("drain_req_valid", {31'd0, bus.md_req_valid}, 32'd0);
        saw_wb = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 33; c++) begin
            bus.kill = (c == 5);
            saw_wb = saw_wb | bus.wb_valid;
            stable = stable & bus.busy;
            tick();
        end
        bus.kill = 1'b0;
        chk("drain_holds", {31'd0, stable}, 32'd1);
        respond(32'h0000_DEAD);
        chk("drain_no_wb", {31'd0, saw_wb | bus.wb_valid}, 32'd0);
        chk("drain_ready_after_resp", {31'd0, bus.cmd_ready}, 32'd1);
        chk("drain_wb_data_kept", bus.wb_data, 32'h0000_1234);

        // kill in WAIT, then a fresh MULHU
        issue(3'd4, 32'd100, 32'd7, 5'd10);
        handshake();
        for (int c = 0; c < 8; c++) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("kill_wait_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        tick();
        respond(32'h0000_0055);
        chk("kill_wait_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("kill_wait_ready", {31'd0, bus.cmd_ready}, 32'd1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
        chk("mulhu_decode", dec_now(), {26'd0, 2'd0, 2'd1, 1'b0, 1'b0});
        handshake();
        for (int c = 0; c < 5; c++) tick();
        respond(32'hFFFF_FFFE);
        chk("mulhu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("mulhu_wb_data", bus.wb_data, 32'hFFFF_FFFE);
        chk("mulhu_wb_rd", {27'd0, bus.wb_rd}, 32'd11);
        tick();

        // kill together with the response in WAIT discards the result
        issue(3'd6, 32'd9, 32'd4, 5'd12);
        handshake();
        tick();
        bus.kill = 1'b1;
        respond(32'h0000_0001);
        bus.kill = 1'b0;
        chk("kill_resp_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("kill_resp_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("kill_resp_data_kept", bus.wb_data, 32'hFFFF_FFFE);

        // kill during WB does not cancel the writeback
        issue(3'd5, 32'h0000_0077, 32'd0, 5'd13);
        bus.kill = 1'b1;
        chk("wb_kill_valid", {31'd0, bus.wb_valid}, 32'd1);
        tick();
        bus.kill = 1'b0;
        chk("wb_kill_data", bus.wb_data, 32'hFFFF_FFFF);
        chk("wb_kill_rd", {27'd0, bus.wb_rd}, 32'd13);

        // stray response in IDLE
        respond(32'h0000_0BAD);
        chk("idle_resp_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("idle_resp_data_kept", bus.wb_data, 32'hFFFF_FFFF);

        // asynchronous reset while waiting
        issue(3'd0, 32'd2, 32'd3, 5'd14);
        handshake();
        tick();
        reset_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, bus.busy}, 32'd0);
        chk("areset_req_valid", {31'd0, bus.md_req_valid}, 32'd0);
        chk("areset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("areset_wb_data", bus.wb_data, 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        respond(32'h0000_0099);
        chk("areset_late_resp_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("areset_late_resp_idle", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/vscale_md_requester.md
Name: vscale_md_requester

Overview:
Pipeline-side initiator for the iterative multiply/divide unit. It accepts one decoded RV32M command (funct3 plus two operands plus destination register), translates it into an md request (op, out_sel, operand signedness), and runs the req/resp handshake. It stalls the issue stage until the result returns, then presents a single-cycle writeback. It also handles pipeline kill, and bypasses divide-by-zero so that case gives ISA results without using the md unit.

Parameters:
XPR_LEN, 32, datapath width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered by issue stage
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_funct3  in  3  RV32M funct3
cmd_rs1  in  XPR_LEN  operand 1
cmd_rs2  in  XPR_LEN  operand 2
cmd_rd  in  REG_ADDR_WIDTH  destination register
kill  in  1  pipeline flush; discard in-flight command
md_req_valid  out  1  request to md unit
md_req_ready  in  1  md unit accepts the request
md_req_op  out  2  MUL=0, DIV=1, DIVU=2, REM=3
md_req_out_sel  out  2  LO=0, HI=1, REM=2
md_req_in_1_signed  out  1  treat operand 1 as signed
md_req_in_2_signed  out  1  treat operand 2 as signed
md_req_in_1  out  XPR_LEN  operand 1
md_req_in_2  out  XPR_LEN  operand 2
md_resp_valid  in  1  single-cycle response strobe
md_resp_result  in  XPR_LEN  response data
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  REG_ADDR_WIDTH  writeback register
wb_data  out  XPR_LEN  writeback data
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, reset_n=0)
  - State goes to IDLE.
  - All registered outputs go to 0: md_req_*, wb_valid, wb_rd, wb_data.
  - cmd_ready=1 and busy=0 during and after reset.
- cmd_ready equals (state==IDLE), combinational.
- Decode of funct3 to op/out_sel/s1/s2; registered at acceptance:
  - 0 MUL: 0/0/1/1
  - 1 MULH: 0/1/1/1
  - 2 MULHSU: 0/1/1/0
  - 3 MULHU: 0/1/0/0
  - 4 DIV: 1/0/1/1
  - 5 DIVU: 2/0/0/0
  - 6 REM: 3/2/1/1
  - 7 REMU: 3/2/0/0
- States: IDLE, REQ, WAIT, WB, DRAIN.
- IDLE:
  - cmd_valid && !kill, with funct3[2]==1 and cmd_rs2==0 (divide-by-zero): load wb_data and go to WB. Load all-ones for funct3 4/5; load cmd_rs1 for funct3 6/7.
  - cmd_valid && !kill otherwise: latch fields and go to REQ.
  - cmd_valid && kill: ignore the command.
  - wb_rd is latched from cmd_rd on every acceptance.
- REQ:
  - md_req_valid=1.
  - All md_req_* fields held stable until the handshake.
  - md_req_ready && !kill: go to WAIT.
  - kill && !md_req_ready: go to IDLE; no request is issued.
  - kill && md_req_ready: go to DRAIN.
- WAIT:
  - md_req_valid=0.
  - md_resp_valid && !kill: wb_data<=md_resp_result, go to WB.
  - kill && md_resp_valid: go to IDLE, result discarded.
  - kill alone: go to DRAIN.
- DRAIN: wait for md_resp_valid, then go to IDLE. No writeback. kill has no further effect.
- WB: wb_valid=1 for exactly one cycle, then go to IDLE. kill is ignored in WB (writeback commits).
- wb_data and wb_rd hold their values after WB until the next load.
- Latency:
  - Accept in cycle N: md_req_valid is high from N+1.
  - Response strobe in cycle M: wb_valid in M+1; cmd_ready again in M+2.
  - Divide-by-zero bypass: wb_valid in N+1.
- Only one command is outstanding; no pipelining.
- md_resp_valid arriving in IDLE, REQ or WB is ignored.
- reset_n asserted mid-operation aborts immediately. The md unit is reset by the same reset.

Test Plan:
- MUL: rs1=7, rs2=6, rd=3; model responder with 34-cycle latency returns 42 -> md_req_op=0, out_sel=0, signed=1/1; wb_valid one cycle with wb_rd=3, wb_data=42; busy high from N+1 to the WB cycle.
- Full decode sweep: funct3 0..7 with nonzero rs2 -> md_req_op/out_sel/signed bits match the table. md_req_in_1/2 equal rs1/rs2 and are held stable while md_req_ready is held low for 5 cycles.
- Divide by zero: DIV rs1=0x80000000, rs2=0 -> no md_req_valid, wb_data=0xFFFFFFFF at N+1. REMU rs1=0x1234, rs2=0 -> wb_data=0x1234.
- Kill in REQ with md_req_ready=0 -> IDLE next cycle, no request, no wb_valid. Kill coincident with the handshake -> DRAIN; response at +34 is swallowed, no wb_valid, cmd_ready returns the cycle after the response.
- Kill in WAIT at cycle 10 -> no writeback; a new MULHU command issued after cmd_ready returns, with rs1=rs2=0xFFFFFFFF and a model response of 0xFFFFFFFE -> wb_data=0xFFFFFFFE.
- Async reset (reset_n low for 2 ns) asserted in WAIT -> busy=0 and md_req_valid=0 immediately; a later md_resp_valid produces no wb_valid.
